// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter (STOP_BITS selects one or two stop bits).
// Each accepted byte goes out LSB first: one start bit, 8 data bits, then
// STOP_BITS stop bits. Every bit is held for CLKS_PER_BIT clock cycles.
//
// Ports:
//   FPGA_CLK   system clock
//   FPGA_RST   synchronous, active-high reset
//   TX_DATA    byte to send, sampled only on the valid/ready handshake
//   TX_VALID   TX_DATA holds a byte to send
//   TX_READY   block can accept a byte this cycle (registered)
//   UART_TXD   serial line, idles high (registered)
//   TX_BUSY    a frame is in progress (registered)
//   TX_DONE    one-cycle pulse in the last cycle of the stop period (registered)
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       FPGA_CLK,
    input  logic       FPGA_RST,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    output logic       TX_READY,
    output logic       UART_TXD,
    output logic       TX_BUSY,
    output logic       TX_DONE
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    // TX_DONE is registered, so it is raised one cycle before the final stop cycle ends
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [2:0]       BIT_LAST  = 3'd7;
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             txd_q, txd_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // State and output registers
    always_ff @(posedge FPGA_CLK) begin
        if (FPGA_RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            txd_q   <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            txd_q   <= txd_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        txd_d   = txd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
                if (TX_VALID && ready_q) begin
                    state_d = START;
                    shreg_d = TX_DATA;
                    txd_d   = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end

            START: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                    txd_d   = shreg_q[0];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                        bit_d   = '0;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = shreg_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            STOP: begin
                txd_d = 1'b1;
                // bit counter doubles as the stop-bit index here
                done_d = (bit_q == STOP_LAST) && (cnt_q == CNT_PRE);
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == STOP_LAST) begin
                        state_d = IDLE;
                        bit_d   = '0;
                        busy_d  = 1'b0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign ready_d  = ~busy_d;

    assign TX_READY = ready_q;
    assign UART_TXD = txd_q;
    assign TX_BUSY  = busy_q;
    assign TX_DONE  = done_q;

endmodule
